// File: rtl/round_sat_pipe.sv
// Two-stage round/saturate for complex FFT samples, with valid/ready flow control
// and per-frame saturation statistics.
module round_sat_lane #(
  parameter int IW      = 16,
  parameter int SH      = 7,
  parameter int OW      = 8,
  parameter int SYM_SAT = 0,
  parameter int RW      = IW - SH + 1
) (
  input  logic [IW-1:0] x_i,
  input  logic [1:0]    mode_i,
  input  logic [RW-1:0] r_i,
  output logic [RW-1:0] rnd_o,
  output logic [OW-1:0] y_o,
  output logic          sat_o
);
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OW - 1)) - 1);
  // ~MAXV is -2^(OW-1); the symmetric limit is one above it
  localparam logic signed [RW-1:0] MINV = (SYM_SAT != 0) ? ~MAXV + RW'(1) : ~MAXV;

  logic [IW-SH-1:0] kept;
  logic             half, sticky, odd, sign, inc;

  assign kept   = x_i[IW-1:SH];
  assign half   = x_i[SH-1];
  assign sticky = |x_i[SH-2:0];
  assign odd    = x_i[SH];
  assign sign   = x_i[IW-1];

  always_comb begin
    inc = 1'b0;
    case (mode_i)
      2'b00: inc = 1'b0;
      2'b01: inc = half;
      2'b10: inc = half & (sticky | odd);
      2'b11: inc = half & (sticky | ~sign);
      default: inc = 1'b0;
    endcase
  end

  // one extra bit so the round-up of the largest kept value cannot wrap
  assign rnd_o = {kept[IW-SH-1], kept} + {{(RW-1){1'b0}}, inc};

  always_comb begin
    y_o   = r_i[OW-1:0];
    sat_o = 1'b0;
    if ($signed(r_i) > MAXV) begin
      y_o   = MAXV[OW-1:0];
      sat_o = 1'b1;
    end else if ($signed(r_i) < MINV) begin
      y_o   = MINV[OW-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

module round_sat_pipe #(
  parameter int IN_WORD_LENGTH   = 16,
  parameter int IN_FLOAT_LENGTH  = 12,
  parameter int OUT_WORD_LENGTH  = 8,
  parameter int OUT_FLOAT_LENGTH = 5,
  parameter int SYM_SAT          = 0,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [IN_WORD_LENGTH-1:0]  i_in,
  input  logic [IN_WORD_LENGTH-1:0]  q_in,
  input  logic                       i_last,
  input  logic [1:0]                 rnd_mode,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [OUT_WORD_LENGTH-1:0] i_out,
  output logic [OUT_WORD_LENGTH-1:0] q_out,
  output logic                       o_last,
  output logic                       o_sat,
  output logic [CNT_WIDTH-1:0]       o_sat_count,
  output logic                       o_sat_sticky
);
  localparam int IW = IN_WORD_LENGTH;
  localparam int OW = OUT_WORD_LENGTH;
  localparam int SH = IN_FLOAT_LENGTH - OUT_FLOAT_LENGTH;
  localparam int RW = IW - SH + 1;

  logic [2:1]               vld_pipe_q;
  logic [1:0][IW-1:0]       x;
  logic [1:0][RW-1:0]       rnd, s1_r_q;
  logic [1:0][OW-1:0]       y, y_q;
  logic [1:0]               sat;
  logic                     s1_last_q, last_q, sat_q;
  logic                     en1, en2, hs;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d, cnt_sat, cnt_out_q, cnt_out_d;
  logic                     sticky_q, sticky_d;

  assign x = {q_in, i_in};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    round_sat_lane #(.IW(IW), .SH(SH), .OW(OW), .SYM_SAT(SYM_SAT), .RW(RW)) u_lane (
      .x_i   (x[g]),
      .mode_i(rnd_mode),
      .r_i   (s1_r_q[g]),
      .rnd_o (rnd[g]),
      .y_o   (y[g]),
      .sat_o (sat[g])
    );
  end

  assign en2     = ~vld_pipe_q[2] | o_ready;
  assign en1     = ~vld_pipe_q[1] | en2;
  assign i_ready = en1;
  assign hs      = vld_pipe_q[2] & o_ready;

  always_comb begin
    cnt_sat   = cnt_q;
    if (sat_q && cnt_q != '1) cnt_sat = cnt_q + CNT_WIDTH'(1);
    cnt_d     = cnt_q;
    cnt_out_d = cnt_out_q;
    if (hs && last_q) begin
      cnt_out_d = cnt_sat;
      cnt_d     = '0;
    end else if (hs) begin
      cnt_d     = cnt_sat;
    end
    sticky_d  = sticky_q | (hs & sat_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_r_q     <= '0;
      s1_last_q  <= 1'b0;
      y_q        <= '0;
      last_q     <= 1'b0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      cnt_out_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      if (en1) begin
        vld_pipe_q[1] <= i_valid;
        if (i_valid) begin
          s1_r_q    <= rnd;
          s1_last_q <= i_last;
        end
      end
      // output regs only move when a real sample advances, so idle outputs stay quiet
      if (en2) begin
        vld_pipe_q[2] <= vld_pipe_q[1];
        if (vld_pipe_q[1]) begin
          y_q    <= y;
          last_q <= s1_last_q;
          sat_q  <= |sat;
        end
      end
      cnt_q     <= cnt_d;
      cnt_out_q <= cnt_out_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o_valid      = vld_pipe_q[2];
  assign i_out        = y_q[0];
  assign q_out        = y_q[1];
  assign o_last       = last_q;
  assign o_sat        = sat_q;
  assign o_sat_count  = cnt_out_q;
  assign o_sat_sticky = sticky_q;
endmodule

// File: tb/tb_round_sat_pipe.sv
// Scoreboard bench for round_sat_pipe: driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_round_sat_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_ready, i_last = 1'b0;
  logic [15:0] i_in = '0, q_in = '0;
  logic [1:0]  rnd_mode = 2'b00;
  logic        o_valid, o_ready = 1'b1, o_last, o_sat, o_sat_sticky;
  logic [7:0]  i_out, q_out, o_sat_count;

  round_sat_pipe dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_in(i_in), .q_in(q_in),
    .i_last(i_last), .rnd_mode(rnd_mode), .o_valid(o_valid), .o_ready(o_ready),
    .i_out(i_out), .q_out(q_out), .o_last(o_last), .o_sat(o_sat),
    .o_sat_count(o_sat_count), .o_sat_sticky(o_sat_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] i, q;
    logic       last, sat, lat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compare on handshake, and check outputs hold while stalled
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_valid) chk("stall_hold", {i_out, q_out, o_last, o_sat}, prev_out);
      prev_stall = o_valid && !o_ready;
      prev_out   = {i_out, q_out, o_last, o_sat};
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(o_valid), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("i_out", 32'(i_out), 32'(e.i));
          chk("q_out", 32'(q_out), 32'(e.q));
          chk("o_last", 32'(o_last), 32'(e.last));
          chk("o_sat", 32'(o_sat), 32'(e.sat));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'(2));
        end
      end
    end
  end

  task automatic send(input logic [15:0] xi, input logic [15:0] xq, input logic [1:0] m,
                      input logic lst, input logic [7:0] ei, input logic [7:0] eq,
                      input logic es, input logic lat);
    bit ok = 0;
    exp_t e;
    i_valid = 1'b1; i_in = xi; q_in = xq; rnd_mode = m; i_last = lst;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (i_ready) begin
        e.i = ei; e.q = eq; e.last = lst; e.sat = es; e.lat = lat; e.cyc = cyc;
        sb.push_back(e);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk); #2;
      if (sb.size() == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'(0));
    chk("rst_i_ready", 32'(i_ready), 32'(1));
    chk("rst_outs", 32'({i_out, q_out, o_last, o_sat}), 32'(0));
    chk("rst_cnt", 32'(o_sat_count), 32'(0));
    chk("rst_sticky", 32'(o_sat_sticky), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // ties: I=+0.015625, Q=-0.015625 under each mode
    send(16'h0040, 16'hFFC0, 2'b00, 0, 8'h00, 8'hFF, 0, 1);
    send(16'h0040, 16'hFFC0, 2'b01, 0, 8'h01, 8'h00, 0, 1);
    send(16'h0040, 16'hFFC0, 2'b10, 0, 8'h00, 8'h00, 0, 1);
    send(16'h0040, 16'hFFC0, 2'b11, 0, 8'h01, 8'hFF, 0, 1);
    drain();

    // per-sample mode switching
    send(16'h00C0, 16'h00C0, 2'b01, 0, 8'h02, 8'h02, 0, 1);
    send(16'h00C0, 16'h00C0, 2'b10, 0, 8'h02, 8'h02, 0, 1);
    send(16'h00C0, 16'h00C0, 2'b01, 0, 8'h02, 8'h02, 0, 1);
    send(16'h00C0, 16'h00C0, 2'b10, 0, 8'h02, 8'h02, 0, 1);
    send(16'h0040, 16'h0040, 2'b10, 0, 8'h00, 8'h00, 0, 1);
    drain();
    chk("sticky_clean", 32'(o_sat_sticky), 32'(0));

    // 16-sample frame, saturating at 2, 8 and the last
    for (int k = 0; k < 16; k++) begin
      case (k)
        2:  send(16'h3FC0, 16'h0000, 2'b01, 0, 8'h7F, 8'h00, 1, 0);
        5:  send(16'h3F80, 16'h0000, 2'b01, 0, 8'h7F, 8'h00, 0, 0);
        8:  send(16'h0000, 16'h8000, 2'b00, 0, 8'h00, 8'h80, 1, 0);
        15: send(16'h7FFF, 16'h0000, 2'b00, 1, 8'h7F, 8'h00, 1, 0);
        default: send(16'(k * 128), 16'h0000, 2'b00, 0, 8'(k), 8'h00, 0, 0);
      endcase
    end
    drain();
    chk("frame1_count", 32'(o_sat_count), 32'(3));
    chk("frame1_sticky", 32'(o_sat_sticky), 32'(1));

    // second frame: counter restarted, one saturating sample
    send(16'h7FFF, 16'h0000, 2'b00, 0, 8'h7F, 8'h00, 1, 0);
    send(16'h0080, 16'h0000, 2'b00, 1, 8'h01, 8'h00, 0, 0);
    drain();
    chk("frame2_count", 32'(o_sat_count), 32'(1));
    chk("frame2_sticky", 32'(o_sat_sticky), 32'(1));

    // backpressure: ramp while output is stalled for 5 cycles
    fork
      begin
        for (int k = 1; k <= 10; k++)
          send(16'(k * 128), 16'(-k * 128), 2'b00, 0, 8'(k), 8'(-k), 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 o_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_i_ready", 32'(i_ready), 32'(0));
        chk("bp_o_valid", 32'(o_valid), 32'(1));
        o_ready = 1'b1;
      end
    join
    drain();

    // reset with two samples in flight
    send(16'h0100, 16'h0000, 2'b00, 0, 8'h02, 8'h00, 0, 0);
    send(16'h7FFF, 16'h0000, 2'b00, 1, 8'h7F, 8'h00, 1, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_o_valid", 32'(o_valid), 32'(0));
    chk("mrst_outs", 32'({i_out, q_out, o_last, o_sat}), 32'(0));
    chk("mrst_cnt", 32'(o_sat_count), 32'(0));
    chk("mrst_sticky", 32'(o_sat_sticky), 32'(0));
    chk("mrst_i_ready", 32'(i_ready), 32'(1));
    send(16'h0180, 16'hFF80, 2'b00, 0, 8'h03, 8'hFF, 0, 1);
    send(16'h8000, 16'h0000, 2'b00, 1, 8'h80, 8'h00, 1, 1);
    drain();
    chk("post_rst_count", 32'(o_sat_count), 32'(1));
    chk("post_rst_sticky", 32'(o_sat_sticky), 32'(1));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
